// File: rtl/ddc_mux_sp_multich.sv
// Demultiplexes a channel-tagged serial sample stream into per-channel FIFOs.
// When every channel has a sample, it emits one aligned vector; optional `DDC_MUX_SP_OVF_CNT_EN adds ovf_cnt.
module ddc_mux_sp_multich #(
   parameter int unsigned DATA_W     = 24,
   parameter int unsigned NUM_CH     = 2,
   parameter int unsigned CHIDX_W    = 4,
   parameter int unsigned FIFO_DEPTH = 4
) (
   input  logic                     CLK,
   input  logic                     nRST,
   input  logic [DATA_W-1:0]        in_data,
   input  logic                     in_valid,
   input  logic [CHIDX_W-1:0]       in_chidx,
   output logic [NUM_CH*DATA_W-1:0] out_data,
   output logic                     out_valid,
   input  logic                     out_ready,
   output logic [NUM_CH-1:0]        ovf_flag,
   output logic                     idx_err,
   input  logic                     clr_err
`ifdef DDC_MUX_SP_OVF_CNT_EN
   ,
   output logic [15:0]              ovf_cnt
`endif
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);
   localparam int unsigned PW = AW + 1;

   logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem_q [NUM_CH];
   logic [FIFO_DEPTH-1:0][DATA_W-1:0] mem_d [NUM_CH];
   logic [PW-1:0]                     wr_ptr_q [NUM_CH];
   logic [PW-1:0]                     wr_ptr_d [NUM_CH];
   logic [PW-1:0]                     rd_ptr_q [NUM_CH];
   logic [PW-1:0]                     rd_ptr_d [NUM_CH];
   logic [NUM_CH*DATA_W-1:0]          out_data_q, out_data_d;
   logic                              out_valid_q, out_valid_d;
   logic [NUM_CH-1:0]                 ovf_q, ovf_d;
   logic                              idx_q, idx_d;
   logic [NUM_CH-1:0]                 empty, full, sel;
   logic                              idx_bad, pop;

   always_comb begin
      for (int k = 0; k < NUM_CH; k++) begin
         empty[k] = (wr_ptr_q[k] == rd_ptr_q[k]);
         full[k]  = (wr_ptr_q[k][AW] != rd_ptr_q[k][AW]) &&
                    (wr_ptr_q[k][AW-1:0] == rd_ptr_q[k][AW-1:0]);
         sel[k]   = in_valid && (32'(in_chidx) == k);
      end
   end

   assign idx_bad = in_valid && (32'(in_chidx) >= NUM_CH);
   assign pop     = ~|empty && (!out_valid_q || out_ready);

   always_comb begin
      mem_d       = mem_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      // A new error in the clear cycle wins over clr_err.
      ovf_d       = clr_err ? '0 : ovf_q;
      idx_d       = (clr_err ? 1'b0 : idx_q) | idx_bad;
      for (int k = 0; k < NUM_CH; k++) begin
         if (sel[k]) begin
            // A full FIFO that pops this cycle frees a slot for the incoming sample.
            if (!full[k] || pop) begin
               mem_d[k][wr_ptr_q[k][AW-1:0]] = in_data;
               wr_ptr_d[k] = wr_ptr_q[k] + PW'(1);
            end else begin
               ovf_d[k] = 1'b1;
            end
         end
         if (pop) begin
            rd_ptr_d[k] = rd_ptr_q[k] + PW'(1);
            out_data_d[k*DATA_W +: DATA_W] = mem_q[k][rd_ptr_q[k][AW-1:0]];
         end
      end
      if (pop) begin
         out_valid_d = 1'b1;
      end else if (out_ready) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         for (int k = 0; k < NUM_CH; k++) begin
            wr_ptr_q[k] <= '0;
            rd_ptr_q[k] <= '0;
         end
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         ovf_q       <= '0;
         idx_q       <= 1'b0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         ovf_q       <= ovf_d;
         idx_q       <= idx_d;
      end
   end

   // Storage needs no reset; only entries between the pointers are ever read.
   always_ff @(posedge CLK) begin
      mem_q <= mem_d;
   end

   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign ovf_flag  = ovf_q;
   assign idx_err   = idx_q;

`ifdef DDC_MUX_SP_OVF_CNT_EN
   logic [15:0] cnt_q, cnt_d;
   logic        drop;

   always_comb begin
      drop  = idx_bad || |(sel & full & ~{NUM_CH{pop}});
      cnt_d = clr_err ? 16'h0000 : cnt_q;
      if (drop && (cnt_d != 16'hFFFF)) begin
         cnt_d = cnt_d + 16'h0001;
      end
   end

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         cnt_q <= 16'h0000;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign ovf_cnt = cnt_q;
`endif

endmodule

// File: tb/tb_ddc_mux_sp_multich.sv
// Directed bench for ddc_mux_sp_multich.
// It uses a 2-channel and a 4-channel instance sharing one clock and reset.
module tb_ddc_mux_sp_multich;
   logic        clk = 1'b0;
   logic        rst_n;
   always #5 clk = ~clk;

   logic [23:0] in_data2, in_data4;
   logic        in_valid2, in_valid4;
   logic [3:0]  in_chidx2, in_chidx4;
   logic [47:0] out_data2;
   logic [95:0] out_data4;
   logic        out_valid2, out_valid4, ready2, ready4;
   logic [1:0]  ovf2;
   logic [3:0]  ovf4;
   logic        idx_err2, idx_err4, clr2, clr4;
`ifdef DDC_MUX_SP_OVF_CNT_EN
   logic [15:0] ovf_cnt2, ovf_cnt4;
`endif

   int n_total = 0;
   int n_pass  = 0;

   ddc_mux_sp_multich #(.DATA_W(24), .NUM_CH(2), .CHIDX_W(4), .FIFO_DEPTH(4)) u_dut2 (
      .CLK(clk), .nRST(rst_n), .in_data(in_data2), .in_valid(in_valid2), .in_chidx(in_chidx2),
      .out_data(out_data2), .out_valid(out_valid2), .out_ready(ready2), .ovf_flag(ovf2),
      .idx_err(idx_err2), .clr_err(clr2)
`ifdef DDC_MUX_SP_OVF_CNT_EN
      , .ovf_cnt(ovf_cnt2)
`endif
   );

   ddc_mux_sp_multich #(.DATA_W(24), .NUM_CH(4), .CHIDX_W(4), .FIFO_DEPTH(4)) u_dut4 (
      .CLK(clk), .nRST(rst_n), .in_data(in_data4), .in_valid(in_valid4), .in_chidx(in_chidx4),
      .out_data(out_data4), .out_valid(out_valid4), .out_ready(ready4), .ovf_flag(ovf4),
      .idx_err(idx_err4), .clr_err(clr4)
`ifdef DDC_MUX_SP_OVF_CNT_EN
      , .ovf_cnt(ovf_cnt4)
`endif
   );

   task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
      n_total++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   // Inputs change just after a negedge and are captured at the following posedge.
   task automatic cyc2(input logic [3:0] ch, input logic [23:0] d);
      in_valid2 = 1'b1; in_chidx2 = ch; in_data2 = d;
      @(negedge clk);
      in_valid2 = 1'b0;
   endtask

   task automatic cyc4(input logic [3:0] ch, input logic [23:0] d);
      in_valid4 = 1'b1; in_chidx4 = ch; in_data4 = d;
      @(negedge clk);
      in_valid4 = 1'b0;
   endtask

   function automatic logic [95:0] set4(input int s);
      logic [95:0] v;
      for (int k = 0; k < 4; k++) v[k*24 +: 24] = 24'(s * 256 + k);
      return v;
   endfunction

   // Channel 0 of dut2 holds b0..b0+3; feed channel 1 and expect pairs in order.
   task automatic drain2(input logic [23:0] b0, input logic [23:0] b1);
      logic [23:0] e0, e1;
      for (int i = 0; i < 4; i++) begin
         cyc2(4'd1, b1 + 24'(i));
         if (i > 0) begin
            e0 = b0 + 24'(i - 1);
            e1 = b1 + 24'(i - 1);
            check("drain_valid", out_valid2, 1'b1);
            check("drain_data", out_data2, {e1, e0});
         end
      end
      @(negedge clk);
      e0 = b0 + 24'd3;
      e1 = b1 + 24'd3;
      check("drain_last", out_data2, {e1, e0});
      @(negedge clk);
      check("drain_empty", out_valid2, 1'b0);
   endtask

   initial begin
      rst_n = 1'b0;
      in_data2 = '0; in_valid2 = 1'b0; in_chidx2 = '0; ready2 = 1'b1; clr2 = 1'b0;
      in_data4 = '0; in_valid4 = 1'b0; in_chidx4 = '0; ready4 = 1'b0; clr4 = 1'b0;
      repeat (2) @(negedge clk);
      check("rst_valid2", out_valid2, 1'b0);
      check("rst_data2", out_data2, 48'h0);
      check("rst_ovf2", ovf2, 2'b00);
      check("rst_idx2", idx_err2, 1'b0);
      check("rst_valid4", out_valid4, 1'b0);
      check("rst_data4", out_data4, 96'h0);
      rst_n = 1'b1;
      @(negedge clk);

      // T1: basic I/Q pair, two-cycle latency, one-cycle valid pulse
      cyc2(4'd0, 24'h000001);
      cyc2(4'd1, 24'hFFFFFF);
      check("t1_not_yet", out_valid2, 1'b0);
      @(negedge clk);
      check("t1_valid", out_valid2, 1'b1);
      check("t1_data", out_data2, {24'hFFFFFF, 24'h000001});
      @(negedge clk);
      check("t1_pulse", out_valid2, 1'b0);

      // T2: back-pressure holds the first set; release yields sets in order
      for (int s = 1; s <= 3; s++)
         for (int k = 0; k < 4; k++) cyc4(4'(k), 24'(s * 256 + k));
      repeat (10) @(negedge clk);
      check("t2_hold_valid", out_valid4, 1'b1);
      check("t2_hold_data", out_data4, set4(1));
      check("t2_no_ovf", ovf4, 4'b0000);
      ready4 = 1'b1;
      @(negedge clk);
      check("t2_set2", out_data4, set4(2));
      @(negedge clk);
      check("t2_set3", out_data4, set4(3));
      check("t2_set3_valid", out_valid4, 1'b1);
      @(negedge clk);
      check("t2_done", out_valid4, 1'b0);

      // T3: overflow on ch0; samples 5 and 6 must be dropped
      ready2 = 1'b0;
      for (int i = 0; i < 6; i++) cyc2(4'd0, 24'h000100 + 24'(i));
      check("t3_ovf", ovf2, 2'b01);
      clr2 = 1'b1;
      @(negedge clk);
      clr2 = 1'b0;
      check("t3_clr", ovf2, 2'b00);
      ready2 = 1'b1;
      drain2(24'h000100, 24'h000200);

      // T4: out-of-range channel index
      cyc2(4'd5, 24'hABCDEF);
      check("t4_idx", idx_err2, 1'b1);
      repeat (3) @(negedge clk);
      check("t4_no_valid", out_valid2, 1'b0);
      check("t4_no_ovf", ovf2, 2'b00);
      clr2 = 1'b1;
      cyc2(4'd5, 24'h123456);
      clr2 = 1'b0;
      check("t4_set_wins", idx_err2, 1'b1);
      clr2 = 1'b1;
      @(negedge clk);
      clr2 = 1'b0;
      check("t4_clr", idx_err2, 1'b0);

      // T5: push into a full FIFO in the cycle it pops is accepted
      for (int i = 0; i < 4; i++) cyc2(4'd0, 24'h000300 + 24'(i));
      cyc2(4'd1, 24'h000400);
      cyc2(4'd0, 24'h000304);
      check("t5_no_ovf", ovf2, 2'b00);
      check("t5_data", out_data2, {24'h000400, 24'h000300});
      drain2(24'h000301, 24'h000401);

      // T6: reset mid-operation discards buffered samples
      cyc4(4'd0, 24'h000700);
      cyc4(4'd1, 24'h000701);
      cyc4(4'd2, 24'h000702);
      cyc4(4'd7, 24'h0007FF);
      check("t6_pre_idx", idx_err4, 1'b1);
      ready2 = 1'b0;
      cyc2(4'd0, 24'h000600);
      cyc2(4'd1, 24'h000601);
      @(negedge clk);
      check("t6_pre_valid2", out_valid2, 1'b1);
      rst_n = 1'b0;
      #1;
      check("t6_rst_valid2", out_valid2, 1'b0);
      check("t6_rst_data2", out_data2, 48'h0);
      check("t6_rst_idx4", idx_err4, 1'b0);
      check("t6_rst_data4", out_data4, 96'h0);
      @(negedge clk);
      rst_n = 1'b1;
      cyc4(4'd3, 24'h000503);
      repeat (2) @(negedge clk);
      check("t6_no_stale", out_valid4, 1'b0);
      cyc4(4'd0, 24'h000500);
      cyc4(4'd1, 24'h000501);
      cyc4(4'd2, 24'h000502);
      @(negedge clk);
      check("t6_new_valid", out_valid4, 1'b1);
      check("t6_new_data", out_data4, {24'h000503, 24'h000502, 24'h000501, 24'h000500});
      check("t6_valid2_idle", out_valid2, 1'b0);

`ifdef DDC_MUX_SP_OVF_CNT_EN
      clr2 = 1'b1;
      @(negedge clk);
      clr2 = 1'b0;
      check("cnt_clr", ovf_cnt2, 16'h0000);
      cyc2(4'd9, 24'h0);
      check("cnt_one", ovf_cnt2, 16'h0001);
      in_valid2 = 1'b1; in_chidx2 = 4'd9;
      repeat (70000) @(negedge clk);
      in_valid2 = 1'b0;
      check("cnt_sat", ovf_cnt2, 16'hFFFF);
`endif

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
